interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
- Upstream of the multicycle control FSM.
- Captures rising edges on the 8 HardwareInterrupt lines into a pending register and applies a mask.
- Picks one line by fixed priority and raises InterruptIn to the control unit, then holds a one-request-in-service handshake until the handler returns.
- Supplies the handler vector/address that the control unit loads into PC (via PCData) after EPCWrite.

Parameters:
NUM_LINES, 8, number of hardware interrupt lines (index width IDX_W = clog2(NUM_LINES) = 3)
HANDLER_BASE, 16'h0100, address of line 0's handler
HANDLER_STRIDE, 16'h0004, byte spacing between consecutive handlers
MASK_RESET, 8'hFF, mask value after reset (1 = enabled)

Ports:
CLK  in  1  system clock, all state on rising edge
RST_N  in  1  synchronous active-low reset
HardwareInterrupt  in  NUM_LINES  raw level lines, already synchronous to CLK
IntAck  in  1  control unit taking the interrupt (driven by its EPCWrite)
IntDone  in  1  handler return (control unit's return-from-interrupt state)
FlippedWrite  in  1  software clear strobe
Flipped  in  NUM_LINES  bits to clear in pending when FlippedWrite=1
InterruptWrite  in  1  mask write strobe
MaskData  in  NUM_LINES  new mask value
InterruptIn  out  1  request to control FSM (registered)
IntVector  out  IDX_W  index of selected/active line (registered)
HandlerAddr  out  16  HANDLER_BASE + IntVector*HANDLER_STRIDE (combinational from IntVector)
Pending  out  NUM_LINES  pending register
Mask  out  NUM_LINES  mask register
InService  out  1  1 while in SERVICE

Behaviour:
- Reset (RST_N=0 at a clock edge):
  - Pending=0, Mask=MASK_RESET, prev-line register=0.
  - state=IDLE, InterruptIn=0, IntVector=0, InService=0.
- Edge detect: rise[i] = HardwareInterrupt[i] & ~prev[i]; prev <= HardwareInterrupt every cycle. A level held high sets pending only once.
- Pending update, per bit, in priority order:
  - rise sets the bit.
  - else the IntAck clear of the active bit (below) clears it.
  - else FlippedWrite&Flipped[i] clears it.
  - else the bit holds.
  - A new edge coincident with a clear is never lost.
- Mask: InterruptWrite loads MaskData next edge; masked bits still accumulate in Pending.
- Eligible = Pending & Mask. Winner = highest set index (bit 7 highest priority).
- FSM:
  - IDLE: IntVector <= winner each cycle. If Eligible != 0, go to REQUEST and set InterruptIn <= 1.
  - REQUEST: InterruptIn=1. IntVector re-arbitrates every cycle, so a higher line arriving before ack wins.
    - If Eligible becomes 0 (software clear or mask write), return to IDLE and InterruptIn <= 0.
    - If IntAck=1, go to SERVICE, clear Pending[IntVector], InterruptIn <= 0, InService <= 1, and freeze IntVector.
  - SERVICE: no new request (no nesting); edges keep accumulating.
    - On IntDone=1, go to IDLE and InService <= 0.
    - If Eligible != 0 on that same cycle, InterruptIn reasserts one cycle later via IDLE.
- IntAck outside REQUEST is ignored. IntDone outside SERVICE is ignored.
- Latency: a line rising before edge k gives Pending set after k, then InterruptIn=1 after k+1 (two cycles). Ack at edge m gives InterruptIn=0 after m.
- Reset mid-SERVICE or mid-REQUEST returns to the reset values immediately; in-flight requests are dropped.
- HandlerAddr arithmetic is 16-bit unsigned and wraps modulo 2^16.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'b00, REQUEST=2'b01, SERVICE=2'b10),
  - NUM_LINES/IDX_W constants,
  - HANDLER_BASE/HANDLER_STRIDE defaults, so the control unit and the PCData mux agree on handler addresses.
- One natural sub-module, int_priority_encoder: a combinational NUM_LINES-to-IDX_W highest-index encoder with a valid output. It is reused by the FSM.

Test Plan:
- Reset then HardwareInterrupt=8'h80 rising, Mask=8'hFF: Pending=8'h80 after 1 edge, InterruptIn=1 after 2 edges, IntVector=7, HandlerAddr=16'h011C.
- In REQUEST with line 2 pending, raise line 5 before IntAck: IntVector changes 2->5. IntAck leaves Pending=8'h04, InterruptIn=0, InService=1.
- InterruptWrite with MaskData=8'hDF, then pulse line 5 (8'h20): Pending=8'h20, InterruptIn stays 0. Then write MaskData=8'hFF: InterruptIn=1 two edges later.
- In SERVICE, pulse line 2 (8'h04): InterruptIn stays 0. IntDone gives InService=0, then InterruptIn=1 next cycle with IntVector=2.
- In REQUEST for line 3, FlippedWrite with Flipped=8'h08 while line 3 rises again on the same edge: Pending bit 3 stays 1 and the request is not withdrawn. Repeat without the rise: state returns to IDLE and InterruptIn=0.
- Assert RST_N=0 during SERVICE with Pending=8'h41: next edge gives all outputs at reset values and Mask=8'hFF. A held-high line does not re-trigger until it falls and rises again.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared constants and state encoding for the interrupt controller, the control
// unit and the PCData mux, so all of them agree on handler addresses.
package interrupt_controller_pkg;

  localparam int NUM_LINES = 8;
  localparam int IDX_W     = $clog2(NUM_LINES);

  localparam logic [15:0]          HANDLER_BASE   = 16'h0100;
  localparam logic [15:0]          HANDLER_STRIDE = 16'h0004;
  localparam logic [NUM_LINES-1:0] MASK_RESET     = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQUEST = 2'b01,
    ST_SERVICE = 2'b10
  } int_state_t;

  // Handler address arithmetic is 16-bit and wraps modulo 2^16.
  function automatic logic [15:0] handler_addr(input logic [IDX_W-1:0] idx);
    logic [15:0] w_idx16;
    w_idx16 = {{(16-IDX_W){1'b0}}, idx};
    return HANDLER_BASE + (w_idx16 * HANDLER_STRIDE);
  endfunction

endpackage

// File: rtl/interrupt_controller_int_priority_encoder.sv
// Combinational highest-index priority encoder; o_valid is low when nothing is
// requested and o_idx then reads zero.
module int_priority_encoder
  import interrupt_controller_pkg::*;
(
  input  logic [NUM_LINES-1:0] i_req,
  output logic [IDX_W-1:0]     o_idx,
  output logic                 o_valid
);

  // Ascending scan: the last set bit seen, i.e. the highest index, wins.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (i_req[i]) begin
        o_idx   = IDX_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-capturing, maskable, fixed-priority interrupt controller with a single
// request-in-service handshake towards the multicycle control FSM.
module interrupt_controller
  import interrupt_controller_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NUM_LINES-1:0] HardwareInterrupt,
  input  logic                 IntAck,
  input  logic                 IntDone,
  input  logic                 FlippedWrite,
  input  logic [NUM_LINES-1:0] Flipped,
  input  logic                 InterruptWrite,
  input  logic [NUM_LINES-1:0] MaskData,
  output logic                 InterruptIn,
  output logic [IDX_W-1:0]     IntVector,
  output logic [15:0]          HandlerAddr,
  output logic [NUM_LINES-1:0] Pending,
  output logic [NUM_LINES-1:0] Mask,
  output logic                 InService
);

  int_state_t           r_state;
  logic [NUM_LINES-1:0] r_prev;
  logic [NUM_LINES-1:0] r_pending;
  logic [NUM_LINES-1:0] r_mask;
  logic                 r_int_req;
  logic [IDX_W-1:0]     r_int_vector;
  logic                 r_in_service;

  logic [NUM_LINES-1:0] w_rise;
  logic [NUM_LINES-1:0] w_eligible;
  logic [NUM_LINES-1:0] w_ack_clr;
  logic [NUM_LINES-1:0] w_pending_next;
  logic [IDX_W-1:0]     w_winner;
  logic                 w_win_valid;
  logic                 w_ack_take;

  assign w_rise     = HardwareInterrupt & ~r_prev;
  assign w_eligible = r_pending & r_mask;

  int_priority_encoder u_prio (
    .i_req   (w_eligible),
    .o_idx   (w_winner),
    .o_valid (w_win_valid)
  );

  // An ack only counts in REQUEST while something is still eligible; a
  // withdrawn request takes precedence over a late ack.
  assign w_ack_take = (r_state == ST_REQUEST) && w_win_valid && IntAck;

  // A rising edge beats both clear sources, so a coincident edge is never lost.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : g_pend
      assign w_ack_clr[gi]      = w_ack_take && (r_int_vector == IDX_W'(gi));
      assign w_pending_next[gi] = w_rise[gi] |
                                  (r_pending[gi] & ~w_ack_clr[gi] &
                                   ~(FlippedWrite & Flipped[gi]));
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state      <= ST_IDLE;
      r_prev       <= '0;
      r_pending    <= '0;
      r_mask       <= MASK_RESET;
      r_int_req    <= 1'b0;
      r_int_vector <= '0;
      r_in_service <= 1'b0;
    end else begin
      r_prev    <= HardwareInterrupt;
      r_pending <= w_pending_next;
      if (InterruptWrite) begin
        r_mask <= MaskData;
      end
      case (r_state)
        ST_IDLE: begin
          r_int_vector <= w_winner;
          if (w_win_valid) begin
            r_state   <= ST_REQUEST;
            r_int_req <= 1'b1;
          end
        end
        ST_REQUEST: begin
          if (!w_win_valid) begin
            r_state      <= ST_IDLE;
            r_int_req    <= 1'b0;
            r_int_vector <= w_winner;
          end else if (IntAck) begin
            // Vector stays frozen on the line being serviced.
            r_state      <= ST_SERVICE;
            r_int_req    <= 1'b0;
            r_in_service <= 1'b1;
          end else begin
            r_int_vector <= w_winner;
          end
        end
        ST_SERVICE: begin
          if (IntDone) begin
            r_state      <= ST_IDLE;
            r_in_service <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_int_req    <= 1'b0;
          r_in_service <= 1'b0;
        end
      endcase
    end
  end

  assign InterruptIn = r_int_req;
  assign IntVector   = r_int_vector;
  assign HandlerAddr = handler_addr(r_int_vector);
  assign Pending     = r_pending;
  assign Mask        = r_mask;
  assign InService   = r_in_service;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scenarios for the interrupt controller plus a randomized run checked
// against a rule-level reference model.
module tb_interrupt_controller;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] HardwareInterrupt;
  logic       IntAck, IntDone, FlippedWrite, InterruptWrite;
  logic [7:0] Flipped, MaskData;
  logic       InterruptIn, InService;
  logic [2:0] IntVector;
  logic [15:0] HandlerAddr;
  logic [7:0] Pending, Mask;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int S_IDLE = 0, S_REQ = 1, S_SVC = 2;
  int         m_st;
  logic [7:0] m_pend, m_mask, m_prev;
  logic       m_req, m_svc;
  logic [2:0] m_vec;

  always #5 CLK = ~CLK;

  interrupt_controller dut (
    .CLK(CLK), .RST_N(RST_N), .HardwareInterrupt(HardwareInterrupt),
    .IntAck(IntAck), .IntDone(IntDone), .FlippedWrite(FlippedWrite),
    .Flipped(Flipped), .InterruptWrite(InterruptWrite), .MaskData(MaskData),
    .InterruptIn(InterruptIn), .IntVector(IntVector), .HandlerAddr(HandlerAddr),
    .Pending(Pending), .Mask(Mask), .InService(InService)
  );

  function automatic int top_index(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  // Reference model: next state from the behavioural rules, using pre-edge values.
  task automatic model_edge();
    logic [7:0] elig, rise, np;
    int w;
    elig = m_pend & m_mask;
    w    = top_index(elig);
    rise = HardwareInterrupt & ~m_prev;
    if (!RST_N) begin
      m_pend = 8'h00; m_mask = 8'hFF; m_prev = 8'h00;
      m_st = S_IDLE; m_req = 0; m_vec = 0; m_svc = 0;
    end else begin
      np = m_pend;
      for (int i = 0; i < 8; i++) begin
        if (rise[i]) np[i] = 1'b1;
        else if (m_st == S_REQ && w >= 0 && IntAck && m_vec == i) np[i] = 1'b0;
        else if (FlippedWrite && Flipped[i]) np[i] = 1'b0;
      end
      m_prev = HardwareInterrupt;
      if (InterruptWrite) m_mask = MaskData;
      case (m_st)
        S_IDLE: begin
          m_vec = (w >= 0) ? 3'(w) : 3'd0;
          if (w >= 0) begin m_st = S_REQ; m_req = 1; end
        end
        S_REQ: begin
          if (w < 0) begin m_st = S_IDLE; m_req = 0; m_vec = 0; end
          else if (IntAck) begin m_st = S_SVC; m_req = 0; m_svc = 1; end
          else m_vec = 3'(w);
        end
        default: if (IntDone) begin m_st = S_IDLE; m_svc = 0; end
      endcase
      m_pend = np;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic reset_dut();
    RST_N = 0; HardwareInterrupt = 0; IntAck = 0; IntDone = 0;
    FlippedWrite = 0; Flipped = 0; InterruptWrite = 0; MaskData = 0;
    tick(); tick();
    RST_N = 1;
  endtask

  task automatic test_reset();
    reset_dut();
    n_tests++; if (InterruptIn !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b exp=0", InterruptIn); end
    n_tests++; if (IntVector !== 3'd0) begin n_fail++; $display("FAIL rst_vec got=%0d exp=0", IntVector); end
    n_tests++; if (Pending !== 8'h00) begin n_fail++; $display("FAIL rst_pend got=%h exp=00", Pending); end
    n_tests++; if (Mask !== 8'hFF) begin n_fail++; $display("FAIL rst_mask got=%h exp=ff", Mask); end
    n_tests++; if (InService !== 1'b0) begin n_fail++; $display("FAIL rst_svc got=%b exp=0", InService); end
    HardwareInterrupt = 8'h80; tick();
    n_tests++; if (Pending !== 8'h80) begin n_fail++; $display("FAIL edge_pend got=%h exp=80", Pending); end
    n_tests++; if (InterruptIn !== 1'b0) begin n_fail++; $display("FAIL edge_req1 got=%b exp=0", InterruptIn); end
    tick();
    n_tests++; if (InterruptIn !== 1'b1) begin n_fail++; $display("FAIL edge_req2 got=%b exp=1", InterruptIn); end
    n_tests++; if (IntVector !== 3'd7) begin n_fail++; $display("FAIL edge_vec got=%0d exp=7", IntVector); end
    n_tests++; if (HandlerAddr !== 16'h011C) begin n_fail++; $display("FAIL edge_addr got=%h exp=011c", HandlerAddr); end
    IntAck = 1; tick(); IntAck = 0;
    n_tests++; if (InService !== 1'b1 || Pending !== 8'h00) begin n_fail++; $display("FAIL edge_ack svc=%b pend=%h exp 1/00", InService, Pending); end
    IntDone = 1; tick(); IntDone = 0; HardwareInterrupt = 0;
    n_tests++; if (InService !== 1'b0) begin n_fail++; $display("FAIL edge_done got=%b exp=0", InService); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_preempt();
    reset_dut();
    HardwareInterrupt = 8'h04; tick(); tick();
    n_tests++; if (IntVector !== 3'd2 || InterruptIn !== 1'b1) begin n_fail++; $display("FAIL pre_vec2 vec=%0d req=%b exp 2/1", IntVector, InterruptIn); end
    HardwareInterrupt = 8'h24; tick(); tick();
    n_tests++; if (IntVector !== 3'd5) begin n_fail++; $display("FAIL pre_vec5 got=%0d exp=5", IntVector); end
    IntAck = 1; tick(); IntAck = 0;
    n_tests++; if (Pending !== 8'h04) begin n_fail++; $display("FAIL pre_pend got=%h exp=04", Pending); end
    n_tests++; if (InterruptIn !== 1'b0 || InService !== 1'b1) begin n_fail++; $display("FAIL pre_ack req=%b svc=%b exp 0/1", InterruptIn, InService); end
    HardwareInterrupt = 0;
    $display("[TB] test_preempt done");
  endtask

  task automatic test_mask();
    reset_dut();
    InterruptWrite = 1; MaskData = 8'hDF; tick(); InterruptWrite = 0;
    HardwareInterrupt = 8'h20; tick(); HardwareInterrupt = 0; tick();
    n_tests++; if (Pending !== 8'h20 || Mask !== 8'hDF) begin n_fail++; $display("FAIL msk_state pend=%h mask=%h exp 20/df", Pending, Mask); end
    tick();
    n_tests++; if (InterruptIn !== 1'b0) begin n_fail++; $display("FAIL msk_blocked got=%b exp=0", InterruptIn); end
    InterruptWrite = 1; MaskData = 8'hFF; tick(); InterruptWrite = 0;
    n_tests++; if (InterruptIn !== 1'b0) begin n_fail++; $display("FAIL msk_early got=%b exp=0", InterruptIn); end
    tick();
    n_tests++; if (InterruptIn !== 1'b1 || IntVector !== 3'd5) begin n_fail++; $display("FAIL msk_unblock req=%b vec=%0d exp 1/5", InterruptIn, IntVector); end
    $display("[TB] test_mask done");
  endtask

  task automatic test_service();
    reset_dut();
    HardwareInterrupt = 8'h01; tick(); HardwareInterrupt = 0; tick();
    IntAck = 1; tick(); IntAck = 0;
    HardwareInterrupt = 8'h04; tick(); HardwareInterrupt = 0; tick();
    n_tests++; if (InterruptIn !== 1'b0 || InService !== 1'b1 || Pending !== 8'h04) begin n_fail++; $display("FAIL svc_nonest req=%b svc=%b pend=%h exp 0/1/04", InterruptIn, InService, Pending); end
    IntDone = 1; tick(); IntDone = 0;
    n_tests++; if (InService !== 1'b0 || InterruptIn !== 1'b0) begin n_fail++; $display("FAIL svc_done svc=%b req=%b exp 0/0", InService, InterruptIn); end
    tick();
    n_tests++; if (InterruptIn !== 1'b1 || IntVector !== 3'd2) begin n_fail++; $display("FAIL svc_rereq req=%b vec=%0d exp 1/2", InterruptIn, IntVector); end
    $display("[TB] test_service done");
  endtask

  task automatic test_flip_collision();
    reset_dut();
    HardwareInterrupt = 8'h08; tick(); HardwareInterrupt = 0; tick();
    HardwareInterrupt = 8'h08; FlippedWrite = 1; Flipped = 8'h08; tick(); FlippedWrite = 0;
    n_tests++; if (Pending[3] !== 1'b1) begin n_fail++; $display("FAIL flip_keep got=%h exp bit3 set", Pending); end
    tick();
    n_tests++; if (InterruptIn !== 1'b1) begin n_fail++; $display("FAIL flip_req got=%b exp=1", InterruptIn); end
    HardwareInterrupt = 0; tick();
    FlippedWrite = 1; tick(); FlippedWrite = 0;
    n_tests++; if (Pending !== 8'h00) begin n_fail++; $display("FAIL flip_clr got=%h exp=00", Pending); end
    tick();
    n_tests++; if (InterruptIn !== 1'b0 || InService !== 1'b0) begin n_fail++; $display("FAIL flip_wd req=%b svc=%b exp 0/0", InterruptIn, InService); end
    $display("[TB] test_flip_collision done");
  endtask

  task automatic test_reset_midservice();
    reset_dut();
    InterruptWrite = 1; MaskData = 8'h7F; tick(); InterruptWrite = 0;
    HardwareInterrupt = 8'h01; tick(); HardwareInterrupt = 0; tick();
    IntAck = 1; tick(); IntAck = 0;
    HardwareInterrupt = 8'h41; tick();
    n_tests++; if (Pending !== 8'h41 || InService !== 1'b1) begin n_fail++; $display("FAIL rms_pre pend=%h svc=%b exp 41/1", Pending, InService); end
    RST_N = 0; tick();
    n_tests++; if (InterruptIn !== 1'b0 || IntVector !== 3'd0 || InService !== 1'b0) begin n_fail++; $display("FAIL rms_ctl req=%b vec=%0d svc=%b exp 0/0/0", InterruptIn, IntVector, InService); end
    n_tests++; if (Pending !== 8'h00 || Mask !== 8'hFF) begin n_fail++; $display("FAIL rms_regs pend=%h mask=%h exp 00/ff", Pending, Mask); end
    // The edge history is cleared by reset, so the held line counts once here.
    RST_N = 1; tick();
    n_tests++; if (Pending !== 8'h41) begin n_fail++; $display("FAIL rms_first got=%h exp=41", Pending); end
    FlippedWrite = 1; Flipped = 8'h41; tick(); FlippedWrite = 0;
    tick(); tick();
    n_tests++; if (Pending !== 8'h00 || InterruptIn !== 1'b0) begin n_fail++; $display("FAIL rms_held pend=%h req=%b exp 00/0", Pending, InterruptIn); end
    HardwareInterrupt = 0; tick(); HardwareInterrupt = 8'h41; tick();
    n_tests++; if (Pending !== 8'h41) begin n_fail++; $display("FAIL rms_retrig got=%h exp=41", Pending); end
    HardwareInterrupt = 0;
    $display("[TB] test_reset_midservice done");
  endtask

  task automatic test_random();
    logic [15:0] exp_addr;
    int errs_before;
    reset_dut();
    errs_before = n_fail;
    for (int c = 0; c < 800; c++) begin
      RST_N             = ($urandom_range(63) != 0);
      HardwareInterrupt = HardwareInterrupt ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      IntAck            = ($urandom_range(2) == 0);
      IntDone           = ($urandom_range(3) == 0);
      FlippedWrite      = ($urandom_range(7) == 0);
      Flipped           = 8'($urandom);
      InterruptWrite    = ($urandom_range(15) == 0);
      MaskData          = 8'($urandom) | 8'($urandom);
      tick();
      exp_addr = 16'h0100 + 16'(m_vec) * 16'd4;
      n_tests++; if (InterruptIn !== m_req) begin n_fail++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", c, InterruptIn, m_req); end
      n_tests++; if (IntVector !== m_vec) begin n_fail++; $display("FAIL rnd_vec cyc=%0d got=%0d exp=%0d", c, IntVector, m_vec); end
      n_tests++; if (HandlerAddr !== exp_addr) begin n_fail++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", c, HandlerAddr, exp_addr); end
      n_tests++; if (Pending !== m_pend) begin n_fail++; $display("FAIL rnd_pend cyc=%0d got=%h exp=%h", c, Pending, m_pend); end
      n_tests++; if (Mask !== m_mask) begin n_fail++; $display("FAIL rnd_mask cyc=%0d got=%h exp=%h", c, Mask, m_mask); end
      n_tests++; if (InService !== m_svc) begin n_fail++; $display("FAIL rnd_svc cyc=%0d got=%b exp=%b", c, InService, m_svc); end
    end
    RST_N = 1; IntAck = 0; IntDone = 0; FlippedWrite = 0; InterruptWrite = 0;
    $display("[TB] test_random done, %0d new failures", n_fail - errs_before);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_preempt();
    test_mask();
    test_service();
    test_flip_collision();
    test_reset_midservice();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
